// File: rtl/nor_flash_arbiter.sv
// Two-requester round-robin arbiter in front of a NOR flash controller.
// Optional watchdog on ISSUE/GAP/WAIT: define FLASH_ARB_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module nor_flash_arbiter #(
    parameter int ADDR_WIDTH     = 20,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r0_req,
    input  logic [1:0]            r0_op,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_gnt,
    output logic                  r0_done,
    input  logic                  r1_req,
    input  logic [1:0]            r1_op,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_gnt,
    output logic                  r1_done,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  fl_read,
    output logic                  fl_write,
    output logic                  fl_erase,
    output logic [ADDR_WIDTH-1:0] fl_addr,
    output logic [DATA_WIDTH-1:0] fl_wdata,
    input  logic                  fl_ready,
    input  logic [DATA_WIDTH-1:0] fl_rdata
);
    typedef enum logic [2:0] {IDLE, ISSUE, GAP, WAIT, DONE} state_t;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_PROGRAM = 2'b01;
    localparam logic [1:0] OP_ERASE   = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    state_t                state_reg, state_next;
    logic                  prio_reg;
    logic                  owner_reg;
    logic                  to_reg;
    logic [1:0]            op_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            gnt_reg;
    logic [1:0]            done_reg;
    logic                  err_reg;
    logic                  read_reg, write_reg, erase_reg;

    logic                  any_req;
    logic                  winner;
    logic                  timeout_hit;
    logic [1:0]            sel_op;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // prio_reg names the requester that wins a tie.
    assign any_req   = r0_req | r1_req;
    assign winner    = (r0_req & r1_req) ? prio_reg : r1_req;
    assign sel_op    = winner ? r1_op    : r0_op;
    assign sel_addr  = winner ? r1_addr  : r0_addr;
    assign sel_wdata = winner ? r1_wdata : r0_wdata;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_reg;

    // rN_done is registered out of DONE, so DONE is entered one cycle before the limit.
    assign timeout_hit = (cnt_reg >= CNT_W'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            cnt_reg <= '0;
        end else if (state_reg == ISSUE || state_reg == GAP || state_reg == WAIT) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = (sel_op == OP_ILLEGAL) ? DONE : ISSUE;
            ISSUE:   if (fl_ready) state_next = GAP;
                     else if (timeout_hit) state_next = DONE;
            GAP:     state_next = timeout_hit ? DONE : WAIT;
            WAIT:    if (fl_ready || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            prio_reg  <= 1'b0;
            owner_reg <= 1'b0;
            to_reg    <= 1'b0;
            op_reg    <= OP_READ;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            gnt_reg   <= 2'b00;
            done_reg  <= 2'b00;
            err_reg   <= 1'b0;
            read_reg  <= 1'b0;
            write_reg <= 1'b0;
            erase_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= 2'b00;
            done_reg  <= 2'b00;
            err_reg   <= 1'b0;
            read_reg  <= 1'b0;
            write_reg <= 1'b0;
            erase_reg <= 1'b0;
            case (state_reg)
                IDLE: if (any_req) begin
                    owner_reg <= winner;
                    op_reg    <= sel_op;
                    addr_reg  <= sel_addr;
                    wdata_reg <= sel_wdata;
                    gnt_reg   <= winner ? 2'b10 : 2'b01;
                    prio_reg  <= ~winner;
                    to_reg    <= 1'b0;
                end
                ISSUE: if (fl_ready) begin
                    read_reg  <= (op_reg == OP_READ);
                    write_reg <= (op_reg == OP_PROGRAM);
                    erase_reg <= (op_reg == OP_ERASE);
                end else if (timeout_hit) begin
                    to_reg <= 1'b1;
                end
                GAP: if (timeout_hit) to_reg <= 1'b1;
                WAIT: if (fl_ready) begin
                    if (op_reg == OP_READ) rdata_reg <= fl_rdata;
                end else if (timeout_hit) begin
                    to_reg <= 1'b1;
                end
                DONE: begin
                    done_reg <= owner_reg ? 2'b10 : 2'b01;
                    err_reg  <= (op_reg == OP_ILLEGAL) | to_reg;
                end
                default: ;
            endcase
        end
    end

    assign r0_gnt    = gnt_reg[0];
    assign r1_gnt    = gnt_reg[1];
    assign r0_done   = done_reg[0];
    assign r1_done   = done_reg[1];
    assign rsp_err   = err_reg;
    assign rsp_rdata = rdata_reg;
    assign busy      = (state_reg != IDLE);
    assign fl_read   = read_reg;
    assign fl_write  = write_reg;
    assign fl_erase  = erase_reg;
    assign fl_addr   = addr_reg;
    assign fl_wdata  = wdata_reg;
endmodule

// File: doc/nor_flash_arbiter.md
NOR_FLASH_ARBITER -- requirements
Module: nor_flash_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 20, address width; DATA_WIDTH, default 16, data width; TIMEOUT_CYCLES, default 1024, watchdog limit in cycles.
REQ-002 clk  input  1  sole clock; all logic on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rN_req  input  1  request from requester N (N = 0, 1); held high until rN_gnt.
REQ-005 rN_op  input  2  00 read, 01 program, 10 sector erase, 11 illegal.
REQ-006 rN_addr  input  ADDR_WIDTH  target address; rN_wdata  input  DATA_WIDTH  program data.
REQ-007 rN_gnt  output  1  one-cycle pulse: request accepted.
REQ-008 rN_done  output  1  one-cycle pulse: requester N's operation complete.
REQ-009 rsp_rdata  output  DATA_WIDTH  read data; rsp_err  output  1  error flag; both valid when any rN_done is high.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 fl_read, fl_write, fl_erase  output  1 each  one-cycle command strobes to the flash controller.
REQ-012 fl_addr  output  ADDR_WIDTH, fl_wdata  output  DATA_WIDTH  command operands, held stable from ISSUE through WAIT.
REQ-013 fl_ready  input  1  controller ready; fl_rdata  input  DATA_WIDTH  controller read data.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, GAP, WAIT, DONE.
REQ-015 IDLE: when any rN_req is high, latch the winner's op, addr, wdata and owner, pulse the winner's rN_gnt in the next cycle, and enter ISSUE (op != 11) or DONE (op == 11).
REQ-016 Arbitration SHALL be round-robin: a sole requester wins; on a tie, the requester not served last wins; after reset, r0 wins the first tie.
REQ-017 The last-served pointer SHALL update only on acceptance.
REQ-018 ISSUE: hold until fl_ready = 1, then pulse exactly one strobe matching op for one cycle and enter GAP.
REQ-019 GAP: one cycle with fl_ready ignored, then enter WAIT.
REQ-020 WAIT: on the first cycle with fl_ready = 1, capture fl_rdata into rsp_rdata (reads only) and enter DONE.
REQ-021 DONE: pulse the owner's rN_done for one cycle, drive rsp_err, return to IDLE.
REQ-022 rsp_err SHALL be 1 for an illegal op and 0 otherwise.
REQ-023 rsp_rdata SHALL hold its last read value across program and erase completions.
REQ-024 Minimum latency from gnt to done for a read SHALL be 4 cycles with fl_ready constantly high.
REQ-025 Requests arriving outside IDLE SHALL wait; no request is lost while rN_req is held.
REQ-026 A requester holding rN_req through its own rN_done SHALL be re-accepted in IDLE, subject to round-robin.
REQ-027 Both rN_gnt SHALL never be high in the same cycle; likewise both rN_done, and any two fl strobes.

Reset
REQ-028 With rst high at a clock edge, state SHALL go to IDLE and pointer to r0.
REQ-029 During reset, all gnt, done, err, busy and strobe outputs SHALL be 0, and fl_addr, fl_wdata and rsp_rdata SHALL be 0.
REQ-030 Reset mid-operation SHALL abandon the operation with no rN_done issued.

Configuration
REQ-031 Macro FLASH_ARB_TIMEOUT_EN defined: a counter clears on entry to ISSUE and increments each cycle in ISSUE, GAP and WAIT.
REQ-032 With FLASH_ARB_TIMEOUT_EN, reaching TIMEOUT_CYCLES SHALL force DONE with rsp_err = 1 and rsp_rdata unchanged.
REQ-033 Macro undefined: no counter is built, waits are unbounded, and rsp_err is set only for illegal ops.

Verification
REQ-034 r0 read addr 0x00100, fl_ready high, fl_rdata 0xBEEF -> r0_gnt, fl_read pulse with fl_addr 0x00100, r0_done 4 cycles after gnt, rsp_rdata 0xBEEF, rsp_err 0.
REQ-035 r0 and r1 both requesting reads continuously -> grants alternate r0, r1, r0, r1 after reset.
REQ-036 r1 program addr 0x0ABCD data 0x1234, fl_ready low for 50 cycles after GAP -> single fl_write pulse, r1_done only after fl_ready rises, rsp_rdata unchanged.
REQ-037 r0 op 11 -> r0_gnt, then r0_done with rsp_err 1, and no fl strobe.
REQ-038 rst asserted in WAIT of an erase -> outputs 0 next cycle, no done, next request accepted normally.
REQ-039 With FLASH_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, fl_ready stuck low -> r0_done with rsp_err 1 exactly 16 cycles after ISSUE entry.
